// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN pipeline stages: lane-count derivation and
// lane-wise unsigned max over packed feature-map beats.
package cnn_pkg;

    // Widest packed beat (lanes * bits) the helpers below handle.
    localparam int unsigned LaneVecMax = 256;

    typedef logic [LaneVecMax-1:0] lane_vec_t;

    function automatic int unsigned calc_pe(input int unsigned k, input int unsigned c);
        return (k + c - 1) / c;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic lane_vec_t lane_max(input lane_vec_t a, input lane_vec_t b,
                                           input int unsigned bit_size, input int unsigned lanes);
        lane_vec_t mask;
        lane_vec_t la;
        lane_vec_t lb;
        lane_vec_t res;
        mask = (lane_vec_t'(1) << bit_size) - lane_vec_t'(1);
        res  = '0;
        for (int unsigned l = 0; l < lanes; l++) begin
            la  = (a >> (l * bit_size)) & mask;
            lb  = (b >> (l * bit_size)) & mask;
            res = res | (((la > lb) ? la : lb) << (l * bit_size));
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer of horizontal maxima, one entry per {col/2, beat}.
// Single write port, asynchronous read port.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter  int Depth = 4,
    parameter  int Width = 8,
    localparam int AddrW = clog2_min1(Depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    // NOTE: storage has no reset; an even row always rewrites an entry before the odd row reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_stage.sv
// 2x2 stride-2 max-pooling stage on the beat/lane pixel stream produced by
// convolution_stage; emits pooled pixels in the same format at half resolution.
module max_pool_stage
    import cnn_pkg::*;
#(
    parameter  int BitSize            = 4,
    parameter  int NumberOfK          = 4,
    parameter  int CyclesPerPixel     = 2,
    parameter  int ImageWidth         = 4,
    localparam int ProcessingElements = calc_pe(NumberOfK, CyclesPerPixel)
) (
    input  logic                                         clk,
    input  logic                                         res_n,
    input  logic                                         in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
    output logic                                         out_ready,
    output logic                                         out_valid,
    output logic [ProcessingElements-1:0][BitSize-1:0]   out_data,
    output logic                                         out_done
);

    localparam int BeatW = clog2_min1(CyclesPerPixel);
    localparam int PosW  = clog2_min1(ImageWidth);
    localparam int Depth = (ImageWidth / 2) * CyclesPerPixel;
    localparam int AddrW = clog2_min1(Depth);
    localparam int LaneW = ProcessingElements * BitSize;

    typedef logic [ProcessingElements-1:0][BitSize-1:0] beat_t;

    if ((ImageWidth % 2) != 0 || ImageWidth < 2) begin : g_bad_width
        $error("max_pool_stage: ImageWidth must be even and at least 2");
    end
    if (LaneW > int'(LaneVecMax)) begin : g_bad_lanes
        $error("max_pool_stage: beat width exceeds cnn_pkg::LaneVecMax");
    end

    logic [BeatW-1:0] beat_cnt;
    logic [PosW-1:0]  col_cnt;
    logic [PosW-1:0]  row_cnt;
    beat_t            hreg [CyclesPerPixel];

    logic             accept;
    logic             last_beat;
    logic             last_col;
    logic             last_row;
    logic             pool_fire;
    logic             buf_wr;
    logic [AddrW-1:0] buf_addr;
    beat_t            hmax;
    beat_t            buf_rd;
    beat_t            pool_max;
    beat_t            pooled;

    assign accept    = in_valid & out_ready;
    assign last_beat = (beat_cnt == BeatW'(CyclesPerPixel - 1));
    assign last_col  = (col_cnt == PosW'(ImageWidth - 1));
    assign last_row  = (row_cnt == PosW'(ImageWidth - 1));
    assign buf_wr    = accept & col_cnt[0] & ~row_cnt[0];
    assign pool_fire = accept & col_cnt[0] & row_cnt[0];
    assign buf_addr  = AddrW'((int'(col_cnt) / 2) * CyclesPerPixel + int'(beat_cnt));

    assign hmax     = LaneW'(lane_max(lane_vec_t'(hreg[beat_cnt]), lane_vec_t'(in_data),
                                      BitSize, ProcessingElements));
    assign pool_max = LaneW'(lane_max(lane_vec_t'(buf_rd), lane_vec_t'(hmax),
                                      BitSize, ProcessingElements));

    pool_line_buffer #(
        .Depth (Depth),
        .Width (LaneW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_addr (buf_addr),
        .wr_data (hmax),
        .rd_addr (buf_addr),
        .rd_data (buf_rd)
    );

    // NOTE: every variable written here gets its default first so no latch is inferred.
    always_comb begin
        pooled = pool_max;
        for (int l = 0; l < ProcessingElements; l++) begin
            if (int'(beat_cnt) * ProcessingElements + l >= NumberOfK) begin
                pooled[l] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            beat_cnt  <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_done  <= 1'b0;
            for (int i = 0; i < CyclesPerPixel; i++) begin
                hreg[i] <= '0;
            end
        end else begin
            out_ready <= 1'b1;
            out_valid <= pool_fire;
            out_done  <= pool_fire & last_row & last_col & last_beat;
            if (pool_fire) begin
                out_data <= pooled;
            end
            if (accept) begin
                if (!col_cnt[0]) begin
                    hreg[beat_cnt] <= in_data;
                end
                if (last_beat) begin
                    beat_cnt <= '0;
                    if (last_col) begin
                        col_cnt <= '0;
                        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_stage.sv
// Self-checking bench for max_pool_stage: scenario tasks compare the DUT stream
// against a 2x2 window-max model computed from whole images.
module tb_max_pool_stage;

    localparam int B  = 4;
    localparam int K  = 4;
    localparam int C  = 2;
    localparam int W  = 4;
    localparam int PE = 2;

    typedef logic [PE-1:0][B-1:0] beat_t;
    typedef struct { beat_t data; logic done; int cyc; } obs_t;
    typedef struct { beat_t data; logic done; } exp_t;

    logic  clk = 1'b0;
    logic  res_n = 1'b1;
    logic  in_valid = 1'b0;
    beat_t in_data = '0;
    logic  out_ready, out_valid, out_done;
    beat_t out_data;

    logic  v3 = 1'b0;
    beat_t d3 = '0;
    logic  ready3, ov3, done3;
    beat_t od3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stray_done = 0;

    logic [3:0] img [W][W][K];
    obs_t  obs_q[$];
    exp_t  exp_q[$];
    int    exp_tq[$];
    beat_t obs3_q[$];

    max_pool_stage #(.BitSize(B), .NumberOfK(K), .CyclesPerPixel(C), .ImageWidth(W)) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_done(out_done)
    );

    max_pool_stage #(.BitSize(B), .NumberOfK(3), .CyclesPerPixel(C), .ImageWidth(W)) dut3 (
        .clk(clk), .res_n(res_n), .in_valid(v3), .in_data(d3),
        .out_ready(ready3), .out_valid(ov3), .out_data(od3), .out_done(done3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) obs_q.push_back('{out_data, out_done, cyc});
        if (out_done && !out_valid) stray_done++;
        if (ov3) obs3_q.push_back(od3);
    end

    // Reference: each pooled pixel is the per-channel max of its 2x2 window.
    task automatic build_expected();
        exp_t e;
        logic [3:0] m;
        for (int pr = 0; pr < W / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++)
                for (int b = 0; b < C; b++) begin
                    for (int l = 0; l < PE; l++) begin
                        m = 0;
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++)
                                if (img[2*pr+dr][2*pc+dc][b*PE+l] > m) m = img[2*pr+dr][2*pc+dc][b*PE+l];
                        e.data[l] = m;
                    end
                    e.done = (pr == W/2-1) && (pc == W/2-1) && (b == C-1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
        exp_tq.delete();
    endtask

    task automatic drive_image(input int gap_max, input int max_beats);
        int n;
        n = 0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                for (int b = 0; b < C; b++)
                    if (n < max_beats) begin
                        repeat ($urandom_range(gap_max, 0)) begin
                            @(negedge clk);
                            in_valid = 1'b0;
                            in_data  = beat_t'($urandom);
                        end
                        @(negedge clk);
                        in_valid = 1'b1;
                        for (int l = 0; l < PE; l++) in_data[l] = img[r][c][b*PE+l];
                        if ((r % 2 == 1) && (c % 2 == 1)) exp_tq.push_back(cyc + 1);
                        n++;
                    end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_outputs(input string name, input int n);
        int budget;
        budget = 200;
        while (obs_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, want %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic fill_const(input logic [3:0] v);
        for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) for (int k = 0; k < K; k++) img[r][c][k] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < K; k++) img[r][c][k] = (k == 0) ? 4'((r * 4 + c + 1) % 16) : 4'd0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) for (int k = 0; k < K; k++) img[r][c][k] = 4'($urandom);
    endtask

    task automatic test_reset();
        #2 res_n = 1'b0;
        #1;
        checks++;
        if ({out_ready, out_valid, out_data, out_done, ready3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {out_ready, out_valid, out_data, out_done, ready3});
        end
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got=%b want=0", out_ready); end
        @(negedge clk);
        checks++;
        if (out_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got=%b want=1", out_ready); end
    endtask

    task automatic test_constant();
        clear_queues();
        fill_const(4'b0101);
        build_expected();
        drive_image(0, W * W * C);
        go_idle();
        wait_outputs("const", 8);
        checks++;
        if (obs_q.size() !== 8) begin errors++; $display("FAIL const_count got=%0d want=8", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].done} !== {exp_q[i].data, exp_q[i].done}) begin
                errors++;
                $display("FAIL const_beat%0d got=%h/%b want=%h/%b", i, obs_q[i].data, obs_q[i].done, exp_q[i].data, exp_q[i].done);
            end
        end
    endtask

    task automatic test_channel0(input string name, input int gap_max);
        logic [3:0] want_ch0 [4];
        want_ch0 = '{4'd6, 4'd8, 4'd14, 4'd15};
        clear_queues();
        fill_ramp();
        build_expected();
        drive_image(gap_max, W * W * C);
        go_idle();
        wait_outputs(name, 8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count got=%0d want=%0d", name, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].done} !== {exp_q[i].data, exp_q[i].done}) begin
                errors++;
                $display("FAIL %s_beat%0d got=%h/%b want=%h/%b", name, i, obs_q[i].data, obs_q[i].done, exp_q[i].data, exp_q[i].done);
            end
            checks++;
            if (obs_q[i].cyc !== exp_tq[i]) begin
                errors++;
                $display("FAIL %s_latency%0d got=cycle %0d want=cycle %0d", name, i, obs_q[i].cyc, exp_tq[i]);
            end
        end
        for (int p = 0; p < 4; p++) if (2 * p < obs_q.size()) begin
            checks++;
            if (obs_q[2*p].data[0] !== want_ch0[p]) begin
                errors++;
                $display("FAIL %s_ch0_pix%0d got=%0d want=%0d", name, p, obs_q[2*p].data[0], want_ch0[p]);
            end
        end
    endtask

    task automatic test_reset_mid_image();
        fill_ramp();
        drive_image(1, 6 * C);
        go_idle();
        res_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_done} !== 2'b00) begin errors++; $display("FAIL midreset_outputs got=%b want=00", {out_valid, out_done}); end
        res_n = 1'b1;
        @(negedge clk);
        test_channel0("midreset", 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] want_ch0 [4];
        want_ch0 = '{4'd14, 4'd12, 4'd6, 4'd15};
        clear_queues();
        fill_ramp();
        build_expected();
        drive_image(0, W * W * C);
        for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) for (int k = 0; k < K; k++) img[r][c][k] = img[r][c][k] ^ 4'b1111;
        build_expected();
        drive_image(0, W * W * C);
        go_idle();
        wait_outputs("b2b", 16);
        checks++;
        if (obs_q.size() !== 16) begin errors++; $display("FAIL b2b_count got=%0d want=16", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if ({obs_q[i].data, obs_q[i].done, obs_q[i].cyc} !== {exp_q[i].data, exp_q[i].done, exp_tq[i]}) begin
                errors++;
                $display("FAIL b2b_beat%0d got=%h/%b@%0d want=%h/%b@%0d", i, obs_q[i].data, obs_q[i].done,
                         obs_q[i].cyc, exp_q[i].data, exp_q[i].done, exp_tq[i]);
            end
        end
        for (int p = 0; p < 4; p++) if (8 + 2 * p < obs_q.size()) begin
            checks++;
            if (obs_q[8+2*p].data[0] !== want_ch0[p]) begin
                errors++;
                $display("FAIL b2b_inv_ch0_pix%0d got=%0d want=%0d", p, obs_q[8+2*p].data[0], want_ch0[p]);
            end
        end
        if (obs_q.size() == 16) begin
            checks++;
            if ({obs_q[7].done, obs_q[15].done, obs_q[6].done, obs_q[14].done} !== 4'b1100) begin
                errors++;
                $display("FAIL b2b_done got=%b want=1100", {obs_q[7].done, obs_q[15].done, obs_q[6].done, obs_q[14].done});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            clear_queues();
            fill_random();
            build_expected();
            drive_image(3, W * W * C);
            go_idle();
            wait_outputs("random", 8);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random%0d_count got=%0d want=%0d", n, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++;
                if ({obs_q[i].data, obs_q[i].done, obs_q[i].cyc} !== {exp_q[i].data, exp_q[i].done, exp_tq[i]}) begin
                    errors++;
                    $display("FAIL random%0d_beat%0d got=%h/%b@%0d want=%h/%b@%0d", n, i, obs_q[i].data, obs_q[i].done,
                             obs_q[i].cyc, exp_q[i].data, exp_q[i].done, exp_tq[i]);
                end
            end
        end
        checks++;
        if (stray_done !== 0) begin errors++; $display("FAIL stray_done got=%0d want=0", stray_done); end
    endtask

    task automatic test_padding();
        int budget;
        obs3_q.delete();
        for (int i = 0; i < W * W * C; i++) begin
            @(negedge clk);
            v3 = 1'b1;
            d3 = 8'hFF;
        end
        @(negedge clk);
        v3 = 1'b0;
        budget = 50;
        while (obs3_q.size() < 8 && budget > 0) begin @(negedge clk); budget--; end
        repeat (4) @(negedge clk);
        checks++;
        if (obs3_q.size() !== 8) begin errors++; $display("FAIL pad_count got=%0d want=8", obs3_q.size()); end
        foreach (obs3_q[i]) begin
            checks++;
            if (obs3_q[i] !== ((i % 2 == 0) ? 8'hFF : 8'h0F)) begin
                errors++;
                $display("FAIL pad_beat%0d got=%h want=%h", i, obs3_q[i], (i % 2 == 0) ? 8'hFF : 8'h0F);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_channel0("ramp", 0);
        test_channel0("gaps", 3);
        test_reset_mid_image();
        test_back_to_back();
        test_random();
        test_padding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
